mc_control_unit: RTL

- Registered multicycle MIPS control unit. Owns the state register and sequences the shared datapath: PC, memory, IR, register file and ALU.
- Produces the full control-signal set, ALU function select and PC write enable. Adds memory wait-state handling, a memory timeout watchdog and a retired-instruction counter.
- Sits between the instruction register/ALU zero flag and the multicycle datapath.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_control_unit_if.sv | 36 +++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/mc_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle control unit
// Purpose: state encodings, opcode/funct constants, alu_op and alu_ctl codes,
//          datapath mux select codes.
// Ports:   none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    S0  = 4'd0,   // fetch
    S1  = 4'd1,   // decode
    S2  = 4'd2,   // memory address
    S3  = 4'd3,   // load read
    S4  = 4'd4,   // load write-back
    S5  = 4'd5,   // store
    S6  = 4'd6,   // R-type execute
    S7  = 4'd7,   // R-type write-back
    S8  = 4'd8,   // branch
    S9  = 4'd9,   // jump
    S10 = 4'd10,  // addi execute
    S11 = 4'd11   // addi write-back
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_CTL_AND = 3'b000;
  localparam logic [2:0] ALU_CTL_OR  = 3'b001;
  localparam logic [2:0] ALU_CTL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTL_SUB = 3'b110;
  localparam logic [2:0] ALU_CTL_SLT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL = 2'b11;

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control unit <-> datapath signal bundle
// Purpose: groups the IR/ALU status inputs and the datapath control outputs.
// Ports:   master = control unit (reads op/funct/zero/mem_ready, drives controls)
//          slave  = datapath (drives op/funct/zero/mem_ready, reads controls)
interface mc_control_unit_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic       reg_write;
  logic       reg_dst;
  logic [1:0] pc_source;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a,
           reg_write, reg_dst, pc_source, alu_src_b, alu_op, alu_ctl
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a,
           reg_write, reg_dst, pc_source, alu_src_b, alu_op, alu_ctl
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - alu_op + funct to ALU function select
// Purpose: combinational ALU control decode.
// Ports:   alu_op (in, 2), funct (in, 6), alu_ctl (out, 3)
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_CTL_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_ctl = ALU_CTL_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_CTL_ADD;
          FUNCT_SUB: alu_ctl = ALU_CTL_SUB;
          FUNCT_AND: alu_ctl = ALU_CTL_AND;
          FUNCT_OR:  alu_ctl = ALU_CTL_OR;
          FUNCT_SLT: alu_ctl = ALU_CTL_SLT;
          default:   alu_ctl = ALU_CTL_ADD;
        endcase
      end
      default: alu_ctl = ALU_CTL_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - registered multicycle MIPS control unit
// Purpose: state register, Moore control decode, memory wait/timeout watchdog,
//          retired-instruction counter. Optional ADDI support under MC_ADDI_EN.
// Ports:   clk, rst (async, active-high)
//          bus        : mc_control_unit_if.master (IR/zero/mem_ready in, controls out)
//          state      : current state (4)
//          illegal_op : one-cycle pulse on an undecodable opcode in decode
//          mem_err    : one-cycle pulse when a memory state times out
//          retired    : completed-instruction count (CNT_W, wraps)
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  mc_control_unit_if.master bus,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;

  state_t        cur, nxt;
  logic [TW-1:0] wd_cnt;
  logic          mem_state, timeout, retire;
  logic          pc_write, pc_write_cond;
  logic [1:0]    alu_op;

  assign mem_state = (cur == S0) || (cur == S3) || (cur == S5);
  // A ready in the final allowed cycle takes priority over the abort.
  assign timeout   = mem_state && !bus.mem_ready && (wd_cnt == TW'(MEM_TIMEOUT - 1));
  assign mem_err   = timeout;
  assign state     = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S0;
      wd_cnt  <= '0;
      retired <= '0;
    end else begin
      cur <= nxt;
      // An abort from S0 stays in S0 but is a fresh entry, so clear on it too.
      if (nxt != cur || timeout)
        wd_cnt <= '0;
      else if (mem_state && !bus.mem_ready)
        wd_cnt <= wd_cnt + 1'b1;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt        = cur;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (cur)
      S0: if (bus.mem_ready) nxt = S1;
      S1: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = S2;
          OP_RTYPE:     nxt = S6;
          OP_BEQ:       nxt = S8;
          OP_J:         nxt = S9;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt = S10;
`endif
          default: begin
            nxt        = S0;
            illegal_op = 1'b1;
          end
        endcase
      end
      S2: nxt = (bus.op == OP_SW) ? S5 : S3;
      S3: if (bus.mem_ready) nxt = S4;
      S5: if (bus.mem_ready) begin
        nxt    = S0;
        retire = 1'b1;
      end
      S6: nxt = S7;
      S4, S7, S8, S9: begin
        nxt    = S0;
        retire = 1'b1;
      end
`ifdef MC_ADDI_EN
      S10: nxt = S11;
      S11: begin
        nxt    = S0;
        retire = 1'b1;
      end
`endif
      default: nxt = S0;
    endcase
    if (timeout) nxt = S0;
  end

  always_comb begin
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.pc_source  = PC_SRC_ALU;
    bus.alu_src_b  = SRC_B_REG;
    alu_op         = ALU_OP_ADD;
    case (cur)
      S0: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write  = bus.mem_ready;
        pc_write      = bus.mem_ready;
      end
      S1: bus.alu_src_b = SRC_B_IMM_SHL;
      S2: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      S3: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S4: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S5: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S6: begin
        bus.alu_src_a = 1'b1;
        alu_op        = ALU_OP_FUNCT;
      end
      S7: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S8: begin
        bus.alu_src_a = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        bus.pc_source = PC_SRC_ALUOUT;
      end
      S9: begin
        pc_write      = 1'b1;
        bus.pc_source = PC_SRC_JUMP;
      end
`ifdef MC_ADDI_EN
      S10: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
      end
      S11: bus.reg_write = 1'b1;
`endif
      default: ;
    endcase
    // Architectural writes must stay quiet for the whole reset pulse.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

  assign bus.pc_en  = pc_write | (pc_write_cond & bus.zero);
  assign bus.alu_op = alu_op;

  mc_alu_decoder u_alu_dec (
    .alu_op  (alu_op),
    .funct   (bus.funct),
    .alu_ctl (bus.alu_ctl)
  );

endmodule
